// File: rtl/regression_predictor.sv
// regression_predictor: evaluates y_hat = B0 + B1*x over a sample stream with a two-stage pipeline.
// Optional residual/SSE outputs are compiled in when REGPRED_RESID_EN is defined.
module regression_predictor #(
  parameter int W     = 20,
  parameter int FRAC  = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coef_ld,
  input  logic [W-1:0]     B0_in,
  input  logic [W-1:0]     B1_in,
  output logic             coef_ack,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     y_hat,
  output logic             out_last,
  output logic             done,
  output logic [CNT_W-1:0] n_out,
`ifdef REGPRED_RESID_EN
  input  logic [W-1:0]     y_in,
  output logic [W-1:0]     resid,
  output logic [2*W-1:0]   sse,
`endif
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    WAIT_COEF = 2'd0,
    RUN       = 2'd1,
    DRAIN     = 2'd2
  } state_t;

  localparam logic [W-1:0] Y_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Y_MIN = {1'b1, {(W-1){1'b0}}};

  // Clamp a W+1 bit signed sum/difference into the W-bit signed range.
  function automatic logic [W-1:0] sat_w1(input logic [W:0] v);
    logic [W-1:0] r;
    if (v[W] == v[W-1]) r = v[W-1:0];
    else if (v[W])      r = Y_MIN;
    else                r = Y_MAX;
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [W-1:0]     b0_q, b0_d, b1_q, b1_d;
  logic             coef_ack_q, coef_ack_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] n_out_q, n_out_d;
  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_p_q, s1_p_d;
  logic             s1_last_q, s1_last_d;
  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     y_hat_q, y_hat_d;
  logic             out_last_q, out_last_d;

  logic             advance, accept, xfer, pipe_empty;
  logic [2*W-1:0]   b1_ext, x_ext, prod_sh;
  logic [W-1:0]     p_sat, y_new;
  logic [W:0]       sum;

`ifdef REGPRED_RESID_EN
  logic [W-1:0]     s1_y_q, s1_y_d;
  logic [W-1:0]     resid_q, resid_d;
  logic [2*W-1:0]   sse_q, sse_d;
  logic [2*W-1:0]   r_ext, sq_sh;
  logic [2*W:0]     acc;
  logic [W:0]       diff;
`endif

  // Handshake: a beat moves on any edge where valid and ready are both high;
  // ready never depends on valid, and a producer holds data stable while valid && !ready.
  assign advance    = !s2_valid_q | out_ready;
  assign in_ready   = (state_q == RUN) & advance;
  assign accept     = in_valid & in_ready;
  assign xfer       = s2_valid_q & out_ready;
  assign pipe_empty = !s1_valid_q & !s2_valid_q;

  // Stage-1 arithmetic: full-width product, floor shift, then clamp to W bits.
  always_comb begin
    b1_ext  = {{W{b1_q[W-1]}}, b1_q};
    x_ext   = {{W{x[W-1]}}, x};
    prod_sh = $signed(b1_ext * x_ext) >>> FRAC;
    if ((&prod_sh[2*W-1:W-1]) | ~(|prod_sh[2*W-1:W-1])) p_sat = prod_sh[W-1:0];
    else if (prod_sh[2*W-1])                            p_sat = Y_MIN;
    else                                                p_sat = Y_MAX;
    sum   = {b0_q[W-1], b0_q} + {s1_p_q[W-1], s1_p_q};
    y_new = sat_w1(sum);
  end

  always_comb begin
    state_d    = state_q;
    b0_d       = b0_q;
    b1_d       = b1_q;
    coef_ack_d = 1'b0;
    done_d     = 1'b0;
    n_out_d    = xfer ? n_out_q + 1'b1 : n_out_q;
    unique case (state_q)
      WAIT_COEF: begin
        if (coef_ld) begin
          b0_d       = B0_in;
          b1_d       = B1_in;
          coef_ack_d = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        // A load racing an acceptance would leave data in flight, so it is dropped.
        if (coef_ld && pipe_empty && !accept) begin
          b0_d       = B0_in;
          b1_d       = B1_in;
          coef_ack_d = 1'b1;
        end
        if (accept && in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (xfer && out_last_q) begin
          done_d  = 1'b1;
          n_out_d = '0;
          state_d = RUN;
        end
      end
      default: state_d = WAIT_COEF;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    y_hat_d    = y_hat_q;
    out_last_d = out_last_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      out_last_d = s1_valid_q & s1_last_q;
      if (s1_valid_q) y_hat_d = y_new;
      s1_valid_d = accept;
      s1_last_d  = accept & in_last;
      if (accept) s1_p_d = p_sat;
    end
  end

`ifdef REGPRED_RESID_EN
  // Residual rides stage 2 with y_hat; SSE adds resid^2 (rescaled) per output beat.
  always_comb begin
    s1_y_d  = s1_y_q;
    resid_d = resid_q;
    diff    = {s1_y_q[W-1], s1_y_q} - {y_new[W-1], y_new};
    if (advance) begin
      if (s1_valid_q) resid_d = sat_w1(diff);
      if (accept)     s1_y_d  = y_in;
    end
    r_ext = {{W{resid_q[W-1]}}, resid_q};
    sq_sh = (r_ext * r_ext) >> FRAC;
    acc   = {1'b0, sse_q} + {1'b0, sq_sh};
    sse_d = sse_q;
    if (done_q) sse_d = '0;
    else if (xfer) begin
      if (acc[2*W] | acc[2*W-1]) sse_d = {1'b0, {(2*W-1){1'b1}}};
      else                       sse_d = acc[2*W-1:0];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_COEF;
      b0_q       <= '0;
      b1_q       <= '0;
      coef_ack_q <= 1'b0;
      done_q     <= 1'b0;
      n_out_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      y_hat_q    <= '0;
      out_last_q <= 1'b0;
`ifdef REGPRED_RESID_EN
      s1_y_q     <= '0;
      resid_q    <= '0;
      sse_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      coef_ack_q <= coef_ack_d;
      done_q     <= done_d;
      n_out_q    <= n_out_d;
      s1_valid_q <= s1_valid_d;
      s1_p_q     <= s1_p_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      y_hat_q    <= y_hat_d;
      out_last_q <= out_last_d;
`ifdef REGPRED_RESID_EN
      s1_y_q     <= s1_y_d;
      resid_q    <= resid_d;
      sse_q      <= sse_d;
`endif
    end
  end

  assign coef_ack  = coef_ack_q;
  assign done      = done_q;
  assign n_out     = n_out_q;
  assign out_valid = s2_valid_q;
  assign y_hat     = y_hat_q;
  assign out_last  = out_last_q;
  assign state_dbg = state_q;
`ifdef REGPRED_RESID_EN
  assign resid     = resid_q;
  assign sse       = sse_q;
`endif

endmodule

// File: tb/tb_regression_predictor.sv
// Bench for regression_predictor: drivers push expected predictions into a queue,
// a negedge monitor pops and compares them as outputs transfer.
module tb_regression_predictor;
  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         coef_ld = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [W-1:0] B0_in = '0, B1_in = '0, x = '0, y_in = '0;
  logic         coef_ack, in_ready, out_valid, out_last, done;
  logic [W-1:0] y_hat;
  logic [7:0]   n_out;
  logic [1:0]   state_dbg;
`ifdef REGPRED_RESID_EN
  logic [W-1:0]   resid;
  logic [2*W-1:0] sse;
`endif

  int           n_vec = 0, n_err = 0, done_cnt = 0, d0;
  logic [2*W:0] exp_q[$];
  logic [2*W:0] mon_e;
  logic [W-1:0] m_b0 = '0, m_b1 = '0, b0r, b1r;
  logic [7:0]   m_n = '0;
  logic         done_pend = 1'b0, sends_done = 1'b0;

  always #5 clk = ~clk;

  regression_predictor dut (
    .clk(clk), .rst(rst), .coef_ld(coef_ld), .B0_in(B0_in), .B1_in(B1_in),
    .coef_ack(coef_ack), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .y_hat(y_hat), .out_last(out_last), .done(done), .n_out(n_out),
`ifdef REGPRED_RESID_EN
    .y_in(y_in), .resid(resid), .sse(sse),
`endif
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [W-1:0] sat20(input longint v);
    logic [W-1:0] r;
    if (v > 524287)       r = 20'h7FFFF;
    else if (v < -524288) r = 20'h80000;
    else                  r = v[W-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] model_y(input logic [W-1:0] b0, input logic [W-1:0] b1,
                                           input logic [W-1:0] xv);
    longint p;
    p = (sx(b1) * sx(xv)) >>> 10;
    return sat20(sx(b0) + sx(sat20(p)));
  endfunction

  // Scoreboard monitor: checks the head entry whenever out_valid, pops on transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_n = '0;
      done_pend = 1'b0;
    end else begin
      if (done) done_cnt++;
      check("done", done, done_pend);
      check("n_out", n_out, m_n);
      done_pend = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          mon_e = exp_q[0];
          check("y_hat", y_hat, mon_e[W-1:0]);
          check("out_last", out_last, mon_e[2*W]);
`ifdef REGPRED_RESID_EN
          check("resid", resid, mon_e[2*W-1:W]);
`endif
          if (out_ready) begin
            void'(exp_q.pop_front());
            m_n = m_n + 8'd1;
            if (mon_e[2*W]) begin
              done_pend = 1'b1;
              m_n = '0;
            end
          end
        end
        if (!out_ready) check("in_ready_stall", in_ready, 0);
      end
    end
  end

  // All driver tasks are entered and return 1 time unit after a rising edge.
  task automatic load_coef(input logic [W-1:0] b0, input logic [W-1:0] b1, input logic exp_ack);
    coef_ld = 1'b1; B0_in = b0; B1_in = b1;
    @(posedge clk); #1;
    coef_ld = 1'b0;
    @(negedge clk);
    check("coef_ack", coef_ack, exp_ack);
    if (exp_ack) begin
      m_b0 = b0;
      m_b1 = b1;
    end
    @(negedge clk);
    check("coef_ack_pulse", coef_ack, 0);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] xv, input logic lv, input logic [W-1:0] yv);
    int n;
    logic [W-1:0] ye;
    in_valid = 1'b1; x = xv; in_last = lv; y_in = yv;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 0, 1);
    else begin
      ye = model_y(m_b0, m_b1, xv);
      exp_q.push_back({lv, sat20(sx(yv) - sx(ye)), ye});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] want);
    int n = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, y_hat, want);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size() == 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", state_dbg, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_coef_ack", coef_ack, 0);
    check("rst_done", done, 0);
    check("rst_n_out", n_out, 0);
    check("rst_y_hat", y_hat, 0);
    check("rst_out_last", out_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    in_valid = 1'b1; x = 20'h00400;
    @(negedge clk);
    check("wait_coef_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Basic evaluation and latency
    load_coef(20'h00400, 20'h00800, 1'b1);
    check("state_run", state_dbg, 1);
    send(20'h00C00, 1'b0, '0);
    @(negedge clk);
    check("lat_cycle1", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2", out_valid, 1);
    check("y_7p0", y_hat, 20'h01C00);
    @(negedge clk);
    check("n_out_1", n_out, 1);
    @(posedge clk); #1;
    wait_idle();

    // Sign, saturation and floor rounding
    load_coef(20'h00000, 20'hFFC00, 1'b1);
    send(20'h00600, 1'b0, '0);
    expect_out("y_neg1p5", 20'hFFA00);
    wait_idle();
    load_coef(20'h00000, 20'h40000, 1'b1);
    send(20'h01000, 1'b0, '0);
    expect_out("y_sat_pos", 20'h7FFFF);
    send(20'hFF000, 1'b0, '0);
    expect_out("y_sat_neg", 20'h80000);
    wait_idle();
    load_coef(20'h7FC00, 20'h00400, 1'b1);
    send(20'h00800, 1'b0, '0);
    expect_out("y_sum_sat", 20'h7FFFF);
    wait_idle();
    load_coef(20'h00000, 20'h00001, 1'b1);
    send(20'hFFFFF, 1'b0, '0);
    expect_out("y_floor", 20'hFFFFF);
    wait_idle();

    // Load racing an input acceptance is ignored
    coef_ld = 1'b1; B0_in = 20'h0ABCD; B1_in = 20'h00C00;
    in_valid = 1'b1; x = 20'h00800; in_last = 1'b0;
    @(negedge clk);
    if (in_ready) exp_q.push_back({1'b0, 20'h0, model_y(m_b0, m_b1, 20'h00800)});
    else check("race_in_ready", in_ready, 1);
    @(posedge clk); #1;
    coef_ld = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("race_no_ack", coef_ack, 0);
    @(posedge clk); #1;
    wait_idle();

    // Five-sample stream with a three-cycle stall
    load_coef(20'h00100, 20'h00200, 1'b1);
    d0 = done_cnt;
    fork
      begin
        for (int i = 0; i < 5; i++) send(20'($urandom_range(0, 20'hFFFFF)), i == 4, '0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_done();
    check("done_once", done_cnt - d0, 1);
    @(negedge clk);
    check("n_out_cleared", n_out, 0);
    check("state_after_drain", state_dbg, 1);
    @(posedge clk); #1;

    // Load while data is in flight is ignored; old coefficients stay in use
    out_ready = 1'b0;
    send(20'h00C00, 1'b0, '0);
    load_coef(20'h12345, 20'h00C00, 1'b0);
    out_ready = 1'b1;
    send(20'hFF400, 1'b1, '0);
    wait_done();
    load_coef(20'h12345, 20'h00C00, 1'b1);
    send(20'h00400, 1'b0, '0);
    expect_out("y_new_coef", 20'h12F45);
    wait_idle();

    // Randomised streams with random backpressure
    for (int blk = 0; blk < 3; blk++) begin
      if (blk == 0) begin
        b0r = 20'($urandom_range(0, 20'hFFFFF));
        b1r = 20'($urandom_range(0, 20'hFFFFF));
      end else begin
        b0r = 20'(int'($urandom_range(0, 65535)) - 32768);
        b1r = 20'(int'($urandom_range(0, 16383)) - 8192);
      end
      load_coef(b0r, b1r, 1'b1);
      sends_done = 1'b0;
      fork
        begin
          for (int i = 0; i < 12; i++) send(20'($urandom_range(0, 20'hFFFFF)), i == 11, '0);
          sends_done = 1'b1;
        end
        begin
          while (!sends_done) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
          end
          out_ready = 1'b1;
        end
      join
      wait_done();
    end

    // Reset with two samples in flight
    out_ready = 1'b0;
    send(20'h00400, 1'b0, '0);
    send(20'h00800, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_b0 = '0; m_b1 = '0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_state", state_dbg, 0);
    out_ready = 1'b1; in_valid = 1'b1; x = 20'h00400;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

`ifdef REGPRED_RESID_EN
    load_coef(20'h00400, 20'h00800, 1'b1);
    send(20'h00400, 1'b0, 20'h00800);
    expect_out("y_resid", 20'h00C00);
    check("resid_m1", resid, 20'hFFC00);
    check("sse_1", sse, 40'h0000000400);
    wait_idle();
`else
    load_coef(20'h00400, 20'h00800, 1'b1);
    send(20'h00C00, 1'b1, '0);
    expect_out("y_after_rst", 20'h01C00);
    wait_done();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regression_predictor.md
Name: regression_predictor

Overview:
- Consumer end of the coefficient datapath: takes the fitted B0/B1 (Q10.10) and evaluates y_hat = B0 + B1*x over a stream of x samples.
- Coefficients load through a one-cycle handshake; samples stream in and out over valid/ready with backpressure.
- Two-stage pipeline with an end-of-stream drain and a sample counter.

Parameters:
- W, 20, data width of x, coefficients and y_hat (signed two's complement)
- FRAC, 10, fractional bits (Q10.10 at default)
- CNT_W, 8, sample counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- coef_ld  in  1  load request for B0_in/B1_in
- B0_in  in  W  intercept, signed Q10.10
- B1_in  in  W  slope, signed Q10.10
- coef_ack  out  1  one-cycle pulse: coefficients accepted
- in_valid  in  1  x sample valid
- in_ready  out  1  block can accept x
- x  in  W  sample, signed Q10.10
- in_last  in  1  qualifies the final sample of a stream
- out_valid  out  1  y_hat valid
- out_ready  in  1  downstream accepts y_hat
- y_hat  out  W  prediction, signed Q10.10, saturated
- out_last  out  1  travels with the prediction of the in_last sample
- done  out  1  one-cycle pulse when a drained stream fully leaves
- n_out  out  CNT_W  predictions emitted in the current stream

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State goes to WAIT_COEF.
  - Coefficient registers, both pipeline valids, y_hat, n_out, coef_ack, done, out_last all clear to 0.
  - in_ready=0 and out_valid=0.
  - rst mid-stream discards in-flight samples with no output.
- FSM:
  - WAIT_COEF: in_ready=0. coef_ld=1 latches B0_in/B1_in and pulses coef_ack the next cycle -> RUN.
  - RUN: coef_ld is accepted only when both pipeline stages are empty; otherwise it is ignored with no ack. Accepting in_valid&in_ready&in_last -> DRAIN.
  - DRAIN: in_ready=0. When the last-tagged result transfers (out_valid&out_ready&out_last), done pulses the next cycle, n_out clears in that same cycle, -> RUN. Coefficients are retained. coef_ld is ignored in DRAIN.
- Pipeline:
  - advance = !out_valid | out_ready.
  - in_ready = (state==RUN) & advance.
  - Stage 1 registers p = B1*x: full 2W signed product, arithmetic shift right by FRAC, truncation toward minus infinity, saturation to W-bit signed range.
  - Stage 2 registers y_hat = sat(B0 + p), computed W+1 bits wide and clamped to [0x80000, 0x7FFFF] at default.
  - Latency: 2 cycles from input acceptance to out_valid with no stall. Throughput: 1 sample/cycle.
  - Stall (out_valid & !out_ready): y_hat, out_last and stage 1 hold stable, and in_ready=0.
  - in_last travels alongside the data.
- Counter: n_out increments on each output transfer and wraps at 2^CNT_W-1 -> 0 with no flag.
- Simultaneous events:
  - coef_ld in the same cycle as an input acceptance in RUN: the load is ignored because the pipeline is not empty after the edge.
  - done and coef_ack never assert together.

Optional Feature:
- Macro: REGPRED_RESID_EN.
- When defined:
  - Adds input y_in (W, sampled with x) and outputs resid (W) and sse (2W).
  - resid = sat(y_in - y_hat), aligned with y_hat.
  - sse accumulates resid^2 >> FRAC with saturation on each output transfer, clears on reset and on done.
- When undefined: these ports and their logic are absent, and the remaining behaviour is unchanged.

Test Plan:
- Load B0=0x00400 (1.0), B1=0x00800 (2.0); send x=0x00C00 (3.0) -> coef_ack one cycle after load; y_hat=0x01C00 (7.0) two cycles after acceptance; n_out=1.
- B0=0, B1=0xFFC00 (-1.0), x=0x00600 (1.5) -> y_hat=0xFFA00 (-1.5); B1=0x40000 (256.0), x=0x01000 (4.0) -> y_hat=0x7FFFF (saturated).
- Stream 5 samples with in_last on the 5th, out_ready held 0 for 3 cycles mid-stream -> y_hat stable during stall; in_ready=0; 5 outputs in order; out_last on the 5th; done pulses once; n_out returns to 0.
- Assert coef_ld with new values while the pipeline holds data -> no coef_ack; subsequent y_hat still uses old coefficients; after drain, coef_ld is acked.
- Assert rst with 2 samples in flight -> next cycle out_valid=0, in_ready=0, state WAIT_COEF; no outputs appear afterward until reload.
- With REGPRED_RESID_EN: B0=0x00400, B1=0x00800, x=0x00400, y_in=0x00800 -> y_hat=0x00C00, resid=0xFFC00 (-1.0), sse=0x00400.
